// File: rtl/serialsubtractor_32bit.sv
// Bit-serial subtractor: one full-adder cell computes a + ~b + ~borrowIn, one bit per clock.
// Latency WIDTH cycles from the accept edge to the done pulse; start is taken only while ready.
module serialsubtractor_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIn,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_carry;
  logic             r_borrow_out;
  logic [CW-1:0]    r_count;

  logic w_sum;
  logic w_carry;
  logic w_last;
  logic w_accept;

  assign w_sum    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_carry  = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
  assign w_last   = (r_count == CW'(WIDTH - 1));
  assign w_accept = start & ready;

  // Handshake flags come straight from the state register, never from inputs.
  assign ready     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign diff      = r_diff;
  assign borrowOut = r_borrow_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_res_sh     <= '0;
      r_diff       <= '0;
      r_carry      <= 1'b0;
      r_borrow_out <= 1'b0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_carry  <= w_carry;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_res_sh <= {w_sum, r_res_sh[WIDTH-1:1]};
          r_count  <= r_count + CW'(1);
          if (w_last) begin
            // Subtraction borrow is the inverted carry out of a + ~b + ~bin.
            r_diff       <= {w_sum, r_res_sh[WIDTH-1:1]};
            r_borrow_out <= ~w_carry;
            r_state      <= S_DONE;
          end
        end
        default: begin
          if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= ~b;
            r_carry  <= ~borrowIn;
            r_res_sh <= '0;
            r_count  <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
